w25q16_rd_seq: RTL and testbench
================================

# w25q16_rd_seq

Read-command sequencer for the W25Q16 SPI flash path. On `start` it walks the 24-bit command/config table by driving `index`, then shifts the opcode and 3-byte address through the SPI byte engine under its own chip-select. It clocks out `RD_LEN` dummy bytes and forwards each returned byte on a valid/ready stream toward the UART transmit side. It sits between the command table (upstream) and the SPI byte engine plus UART TX (downstream).

## Interface
- `CMD_NUM`, 2: table entries used; entry 0 = 1-byte opcode in bits [7:0]; entries 1..CMD_NUM-1 = 3-byte fields, sent [23:16], [15:8], [7:0].
- `RD_LEN`, 16: bytes read per transaction, 1..65535.
- `T_CSS`, 4: `sys_clk` cycles from `cs_n` falling to the first `tx_req`.
- `T_CSH`, 8: minimum `sys_clk` cycles `cs_n` stays high after a transaction.
- `sys_clk` in 1: single clock.
- `sys_rst_n` in 1: reset, synchronous, active-low.
- `start` in 1: one-cycle request; honoured only in IDLE.
- `index` out 8: table address.
- `spi_wrdata` in 24: table entry at `index`, combinational.
- `cs_n` out 1: flash chip-select.
- `tx_byte` out 8: byte to the SPI engine.
- `tx_req` out 1: level request; held until `tx_done`.
- `tx_done` in 1: one-cycle pulse; byte exchange complete.
- `rx_byte` in 8: MISO byte, valid with `tx_done`.
- `rd_data` out 8: read byte.
- `rd_valid` out 1; `rd_ready` in 1: stream handshake.
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse at completion.

## Operation
- States: IDLE → CSS → CMD → ADDR → (DUMMY) → READ → OUT → CSH → IDLE.
- IDLE: `cs_n`=1. `start` loads `index`=0, clears counters, and enters CSS.
- CSS: `cs_n`=0; count `T_CSS` cycles, then CMD.
- CMD: `tx_byte`=`spi_wrdata[7:0]` at `index` 0. On `tx_done`, `index`←1, then ADDR.
- ADDR: byte counter 0..2 selects [23:16], [15:8], [7:0]. After the third `tx_done`, `index`++. When `index`==CMD_NUM, go to DUMMY or READ; otherwise repeat ADDR.
- READ: `tx_byte`=8'hFF. On `tx_done`, latch `rx_byte` into `rd_data`, assert `rd_valid`, enter OUT.
- OUT: hold `rd_data`/`rd_valid` until `rd_ready`. No new `tx_req` while `rd_valid`=1, so the SPI clock stalls under backpressure. After the transfer, if read count == RD_LEN−1, go to CSH; otherwise return to READ.
- CSH: `cs_n`=1; count `T_CSH` cycles, pulse `done`, return to IDLE.
- `start` outside IDLE is ignored and not queued.
- `tx_done` outside an active request is ignored.
- Read counter is 16 bits; reaching RD_LEN−1 ends the read; no wrap.

## Timing
- Reset values: `cs_n`=1, `tx_req`=0, `tx_byte`=0, `index`=0, `rd_data`=0, `rd_valid`=0, `busy`=0, `done`=0.
- Reset mid-transaction: all outputs return to reset values on the next edge, including `cs_n`=1. A pending `rd_valid` is dropped.
- `start` registered at edge N → `busy`=1, `cs_n`=0 at N+1. The first `tx_req` rises at N+1+T_CSS.
- `tx_req` falls the cycle after `tx_done` and stays low at least one cycle before the next byte. `tx_byte` is stable while `tx_req`=1.
- `rd_valid` rises the cycle after `tx_done`. Transfer happens on an edge with `rd_valid` && `rd_ready`. The next `tx_req` rises the cycle after the transfer at the earliest.
- `rd_ready` held high: one byte per (engine latency + 2) cycles.
- `done` asserts on the last CSH cycle. `busy` drops on the following edge, and a `start` in that same cycle is accepted.

## Configuration
- `W25Q_RD_DUMMY_EN` defined: DUMMY state sends one 8'hFF after the address. The returned byte is discarded and never presented on `rd_valid`. This supports opcode 0x0B fast read.
- Undefined: ADDR goes directly to READ; DUMMY logic is absent.

## Structure
- Shared package `w25q16_pkg`: state enum, `W25Q_DUMMY_BYTE` = 8'hFF, opcode constants (0x03, 0x0B, 0x06, 0xC7).
- One sub-module `spi_cs_timer`: a loadable down-counter that generates the CSS/CSH waits. All other logic stays in the FSM.

## Test plan
- Table {0x000003, 0x000425}, RD_LEN=4, model returns A0..A3, `rd_ready`=1 → MOSI 03 00 04 25 FF×4; stream A0 A1 A2 A3; one `done`; `cs_n` low throughout the transaction.
- `rd_ready` low for 10 cycles after the first byte → `rd_data`=A0 held; no `tx_req` during the stall; the sequence resumes correctly.
- `start` pulsed during ADDR and again on the `done` cycle → the first is ignored; the second begins a new transaction with `busy` continuous.
- `sys_rst_n` low during READ byte 2 → next edge `cs_n`=1, `rd_valid`=0, `index`=0; a following `start` performs a full clean transaction.
- `W25Q_RD_DUMMY_EN` defined, opcode 0x0B → MOSI 0B 00 04 25 FF FF×4; the dummy response 0x5A is not output.
- T_CSS=4, T_CSH=8 → exactly 4 cycles from `cs_n` falling to `tx_req`; `cs_n` high for 8 cycles before `done`.

Source files
------------

// File: rtl/w25q16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : w25q16_pkg
//  Description : Shared types and constants for the W25Q16 read sequencer:
//                FSM state enum, dummy/filler byte, flash opcodes and a
//                byte-select helper for 3-byte table fields.
//  Revision    : 1.0 - initial release
// ============================================================================
package w25q16_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CSS   = 3'd1,
        ST_CMD   = 3'd2,
        ST_ADDR  = 3'd3,
        ST_DUMMY = 3'd4,
        ST_READ  = 3'd5,
        ST_OUT   = 3'd6,
        ST_CSH   = 3'd7
    } state_t;

    // Byte clocked out on MOSI while only MISO data matters
    localparam logic [7:0] W25Q_DUMMY_BYTE   = 8'hFF;

    localparam logic [7:0] W25Q_OP_READ       = 8'h03;
    localparam logic [7:0] W25Q_OP_FAST_READ  = 8'h0B;
    localparam logic [7:0] W25Q_OP_WREN       = 8'h06;
    localparam logic [7:0] W25Q_OP_CHIP_ERASE = 8'hC7;

    // Most-significant byte first: sel 0 -> [23:16], 1 -> [15:8], else [7:0]
    function automatic logic [7:0] field_byte(input logic [23:0] field,
                                              input logic [1:0]  sel);
        case (sel)
            2'd0:    field_byte = field[23:16];
            2'd1:    field_byte = field[15:8];
            default: field_byte = field[7:0];
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_cs_timer.sv
`default_nettype none
// ============================================================================
//  Module      : spi_cs_timer
//  Description : Loadable down-counter used for chip-select setup and hold
//                waits. Load value N gives N+1 cycles until o_zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_cs_timer
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero,
    output logic             o_one
);

    logic [WIDTH-1:0] r_count;

    // Load has priority; otherwise count down and stop at zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);
    assign o_one  = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/w25q16_rd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : w25q16_rd_seq
//  Description : W25Q16 read-command sequencer. Walks the command table,
//                shifts opcode + address through the SPI byte engine under
//                its own chip-select, reads RD_LEN bytes and forwards them on
//                a valid/ready stream with full backpressure.
//  Options     : W25Q_RD_DUMMY_EN - insert one discarded dummy byte after the
//                address (fast read, opcode 0x0B).
//  Revision    : 1.0 - initial release
// ============================================================================
module w25q16_rd_seq
    import w25q16_pkg::*;
#(
    parameter int CMD_NUM = 2,
    parameter int RD_LEN  = 16,
    parameter int T_CSS   = 4,
    parameter int T_CSH   = 8
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    output logic [7:0]  index,
    input  logic [23:0] spi_wrdata,
    output logic        cs_n,
    output logic [7:0]  tx_byte,
    output logic        tx_req,
    input  logic        tx_done,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0]  c_CMD_NUM  = 8'(CMD_NUM);
    localparam logic [15:0] c_RD_LAST  = 16'(RD_LEN - 1);
    localparam logic [15:0] c_CSS_LOAD = 16'(T_CSS - 1);
    localparam logic [15:0] c_CSH_LOAD = 16'(T_CSH - 1);

`ifdef W25Q_RD_DUMMY_EN
    localparam state_t c_ST_AFTER_ADDR = ST_DUMMY;
`else
    localparam state_t c_ST_AFTER_ADDR = ST_READ;
`endif

    state_t      r_state;
    logic [7:0]  r_index;
    logic [1:0]  r_byte_cnt;
    logic [15:0] r_rd_cnt;
    logic        r_cs_n;
    logic [7:0]  r_tx_byte;
    logic        r_tx_req;
    logic [7:0]  r_rd_data;
    logic        r_rd_valid;
    logic        r_busy;
    logic        r_done;

    logic        w_accept_start;
    logic        w_enter_csh;
    logic        w_tmr_load;
    logic [15:0] w_tmr_val;
    logic        w_tmr_zero;
    logic        w_tmr_one;

    // A start is taken in IDLE or on the final CSH cycle (back-to-back)
    assign w_accept_start = start && ((r_state == ST_IDLE) ||
                                      ((r_state == ST_CSH) && w_tmr_zero));
    assign w_enter_csh    = (r_state == ST_OUT) && rd_ready &&
                            (r_rd_cnt == c_RD_LAST);
    assign w_tmr_load     = w_accept_start || w_enter_csh;
    assign w_tmr_val      = w_enter_csh ? c_CSH_LOAD : c_CSS_LOAD;

    spi_cs_timer #(
        .WIDTH      (16)
    ) u_cs_timer (
        .clk        (sys_clk),
        .rst_n      (sys_rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero),
        .o_one      (w_tmr_one)
    );

    // Sequencer FSM: every output is registered here
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state    <= ST_IDLE;
            r_index    <= 8'd0;
            r_byte_cnt <= 2'd0;
            r_rd_cnt   <= 16'd0;
            r_cs_n     <= 1'b1;
            r_tx_byte  <= 8'd0;
            r_tx_req   <= 1'b0;
            r_rd_data  <= 8'd0;
            r_rd_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_start) begin
                        r_state    <= ST_CSS;
                        r_cs_n     <= 1'b0;
                        r_busy     <= 1'b1;
                        r_index    <= 8'd0;
                        r_byte_cnt <= 2'd0;
                        r_rd_cnt   <= 16'd0;
                    end
                end

                ST_CSS: begin
                    if (w_tmr_zero) begin
                        r_state   <= ST_CMD;
                        r_tx_req  <= 1'b1;
                        r_tx_byte <= spi_wrdata[7:0];
                    end
                end

                ST_CMD: begin
                    if (r_tx_req && tx_done) begin
                        r_tx_req <= 1'b0;
                        r_index  <= 8'd1;
                        r_state  <= (CMD_NUM == 1) ? c_ST_AFTER_ADDR : ST_ADDR;
                    end
                end

                ST_ADDR: begin
                    if (!r_tx_req) begin
                        r_tx_req  <= 1'b1;
                        r_tx_byte <= field_byte(spi_wrdata, r_byte_cnt);
                    end else if (tx_done) begin
                        r_tx_req <= 1'b0;
                        if (r_byte_cnt == 2'd2) begin
                            r_byte_cnt <= 2'd0;
                            r_index    <= r_index + 8'd1;
                            if (r_index + 8'd1 == c_CMD_NUM) begin
                                r_state <= c_ST_AFTER_ADDR;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + 2'd1;
                        end
                    end
                end

`ifdef W25Q_RD_DUMMY_EN
                ST_DUMMY: begin
                    // Response to the dummy byte is intentionally dropped
                    if (!r_tx_req) begin
                        r_tx_req  <= 1'b1;
                        r_tx_byte <= W25Q_DUMMY_BYTE;
                    end else if (tx_done) begin
                        r_tx_req <= 1'b0;
                        r_state  <= ST_READ;
                    end
                end
`endif

                ST_READ: begin
                    if (!r_tx_req) begin
                        r_tx_req  <= 1'b1;
                        r_tx_byte <= W25Q_DUMMY_BYTE;
                    end else if (tx_done) begin
                        r_tx_req   <= 1'b0;
                        r_rd_data  <= rx_byte;
                        r_rd_valid <= 1'b1;
                        r_state    <= ST_OUT;
                    end
                end

                ST_OUT: begin
                    // No SPI traffic until the byte is taken downstream
                    if (rd_ready) begin
                        r_rd_valid <= 1'b0;
                        if (r_rd_cnt == c_RD_LAST) begin
                            r_state <= ST_CSH;
                            r_cs_n  <= 1'b1;
                            if (T_CSH == 1) begin
                                r_done <= 1'b1;
                            end
                        end else begin
                            r_rd_cnt <= r_rd_cnt + 16'd1;
                            r_state  <= ST_READ;
                        end
                    end
                end

                ST_CSH: begin
                    if (w_tmr_zero) begin
                        if (w_accept_start) begin
                            r_state    <= ST_CSS;
                            r_cs_n     <= 1'b0;
                            r_index    <= 8'd0;
                            r_byte_cnt <= 2'd0;
                            r_rd_cnt   <= 16'd0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (w_tmr_one) begin
                        r_done <= 1'b1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign index    = r_index;
    assign cs_n     = r_cs_n;
    assign tx_byte  = r_tx_byte;
    assign tx_req   = r_tx_req;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_w25q16_rd_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_w25q16_rd_seq
//  Description : Self-checking bench for w25q16_rd_seq with a behavioural SPI
//                byte engine and a table-driven expected MOSI/read stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_w25q16_rd_seq;

    localparam int CMD_NUM = 2;
    localparam int RD_LEN  = 4;
    localparam int T_CSS   = 4;
    localparam int T_CSH   = 8;
`ifdef W25Q_RD_DUMMY_EN
    localparam bit DUMMY = 1'b1;
`else
    localparam bit DUMMY = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic [7:0]  index;
    logic [23:0] spi_wrdata;
    logic        cs_n;
    logic [7:0]  tx_byte;
    logic        tx_req;
    logic        tx_done;
    logic [7:0]  rx_byte;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        busy;
    logic        done;

    logic [23:0] tbl [CMD_NUM];

    int n_checks = 0;
    int n_pass   = 0;

    bq_t  miso_q, got_mosi, got_rd, exp_mosi, exp_rd;
    int   xfer_cyc[$];
    int   cyc = 0;
    int   eng_lat = 2;
    int   eng_cnt = 0;
    int   hold_bad = 0;
    int   req_in_valid = 0;
    int   req_cs_high = 0;
    int   done_cnt = 0;
    logic [7:0] held;

    // results of the last do_txn
    bit   done_seen, to_flag;
    int   css_gap, csh_high, busy_low, stall_bad;

    always #5 sys_clk = ~sys_clk;

    w25q16_rd_seq #(
        .CMD_NUM    (CMD_NUM),
        .RD_LEN     (RD_LEN),
        .T_CSS      (T_CSS),
        .T_CSH      (T_CSH)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .start      (start),
        .index      (index),
        .spi_wrdata (spi_wrdata),
        .cs_n       (cs_n),
        .tx_byte    (tx_byte),
        .tx_req     (tx_req),
        .tx_done    (tx_done),
        .rx_byte    (rx_byte),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .busy       (busy),
        .done       (done)
    );

    // combinational command table
    always_comb begin
        spi_wrdata = 24'h0;
        for (int e = 0; e < CMD_NUM; e++) begin
            if (index == 8'(e)) spi_wrdata = tbl[e];
        end
    end

    // SPI byte engine model: eng_lat cycles of tx_req, then a one-cycle tx_done
    initial begin
        tx_done = 1'b0;
        rx_byte = 8'h00;
        forever begin
            @(posedge sys_clk);
            #1;
            if (!sys_rst_n || !tx_req) begin
                tx_done = 1'b0;
                eng_cnt = 0;
            end else if (tx_done) begin
                tx_done = 1'b0;
            end else begin
                if (eng_cnt == 0) held = tx_byte;
                else if (tx_byte !== held) hold_bad++;
                eng_cnt++;
                if (eng_cnt >= eng_lat) begin
                    tx_done = 1'b1;
                    got_mosi.push_back(tx_byte);
                    rx_byte = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
                    eng_cnt = 0;
                end
            end
        end
    end

    // stream / protocol monitor, sampled mid-cycle
    always @(negedge sys_clk) begin
        cyc++;
        if (sys_rst_n) begin
            if (rd_valid && rd_ready) begin
                got_rd.push_back(rd_data);
                xfer_cyc.push_back(cyc);
            end
            if (tx_req && rd_valid) req_in_valid++;
            if (tx_req && cs_n)     req_cs_high++;
            if (done)               done_cnt++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int q_diff(input bq_t a, input bq_t b);
        int n;
        n = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        for (int i = 0; i < a.size() && i < b.size(); i++) begin
            if (a[i] !== b[i]) n++;
        end
        return n;
    endfunction

    task automatic set_table(input logic [7:0] op, input logic [23:0] addr);
        tbl[0] = {16'h0000, op};
        for (int e = 1; e < CMD_NUM; e++) tbl[e] = addr;
    endtask

    task automatic clear_obs();
        got_mosi.delete(); got_rd.delete(); exp_mosi.delete(); exp_rd.delete();
        miso_q.delete(); xfer_cyc.delete();
        hold_bad = 0; req_in_valid = 0; req_cs_high = 0; done_cnt = 0;
    endtask

    // Reference model: expected MOSI bytes and read stream for one transaction
    task automatic prep_txn(input bit fixed);
        logic [7:0] d;
        exp_mosi.push_back(tbl[0][7:0]);
        miso_q.push_back(8'($urandom));
        for (int e = 1; e < CMD_NUM; e++) begin
            exp_mosi.push_back(tbl[e][23:16]);
            exp_mosi.push_back(tbl[e][15:8]);
            exp_mosi.push_back(tbl[e][7:0]);
            repeat (3) miso_q.push_back(8'($urandom));
        end
        if (DUMMY) begin
            exp_mosi.push_back(8'hFF);
            miso_q.push_back(8'h5A);
        end
        for (int i = 0; i < RD_LEN; i++) begin
            d = fixed ? 8'(8'hA0 + i) : 8'($urandom_range(0, 255));
            exp_mosi.push_back(8'hFF);
            miso_q.push_back(d);
            exp_rd.push_back(d);
        end
    endtask

    // Runs one transaction until done (bounded); stimulus only
    task automatic do_txn(input int stall_len, input logic [7:0] stall_exp,
                          input bit poke_addr, input bit restart,
                          input bit skip_start, input bit rnd_rdy);
        int t_csfall, t_req, stall_left, mosi0;
        bit stalled, poked;
        t_csfall = -1; t_req = -1; stall_left = 0; stalled = 0; poked = 0;
        done_seen = 0; csh_high = 0; busy_low = 0; stall_bad = 0;
        mosi0 = got_mosi.size();
        if (!skip_start) begin
            start = 1'b1;
            @(posedge sys_clk); #1;
            start = 1'b0;
        end
        for (int t = 0; t < 2000 && !done_seen; t++) begin
            if (!busy) busy_low++;
            if (!cs_n && t_csfall < 0) t_csfall = t;
            if (tx_req && t_req < 0) t_req = t;
            if (cs_n) csh_high++;
            if (poke_addr && !poked && got_mosi.size() == mosi0 + 2) begin
                start = 1'b1;
                poked = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (stall_len > 0 && !stalled && rd_valid) begin
                stalled = 1'b1;
                stall_left = stall_len;
            end
            if (stall_left > 0) begin
                rd_ready = 1'b0;
                if (!(rd_valid && rd_data === stall_exp && !tx_req)) stall_bad++;
                stall_left--;
            end else begin
                rd_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (done) begin
                done_seen = 1'b1;
                if (restart) start = 1'b1;
            end
            @(posedge sys_clk); #1;
        end
        start    = 1'b0;
        rd_ready = 1'b1;
        to_flag  = !done_seen;
        css_gap  = t_req - t_csfall;
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        n_checks++; if (cs_n !== 1'b1)     $display("FAIL reset_cs_n: got %b want 1", cs_n); else n_pass++;
        n_checks++; if (tx_req !== 1'b0)   $display("FAIL reset_tx_req: got %b want 0", tx_req); else n_pass++;
        n_checks++; if (tx_byte !== 8'h00) $display("FAIL reset_tx_byte: got %h want 00", tx_byte); else n_pass++;
        n_checks++; if (index !== 8'h00)   $display("FAIL reset_index: got %h want 00", index); else n_pass++;
        n_checks++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h want 00", rd_data); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0)     $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0)     $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        sys_rst_n = 1'b1;
        repeat (2) @(posedge sys_clk);
        #1;
    endtask

    task automatic test_basic();
        int gap_bad;
        clear_obs();
        eng_lat = 2;
        set_table(DUMMY ? 8'h0B : 8'h03, 24'h000425);
        prep_txn(1'b1);
        do_txn(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        gap_bad = 0;
        for (int i = 1; i < xfer_cyc.size(); i++) begin
            if (xfer_cyc[i] - xfer_cyc[i-1] != eng_lat + 2) gap_bad++;
        end
        n_checks++; if (to_flag !== 1'b0)  $display("FAIL basic_timeout: done not seen"); else n_pass++;
        n_checks++; if (q_diff(got_mosi, exp_mosi) !== 0) $display("FAIL basic_mosi: %0d bytes differ (got %0d want %0d bytes)", q_diff(got_mosi, exp_mosi), got_mosi.size(), exp_mosi.size()); else n_pass++;
        n_checks++; if (q_diff(got_rd, exp_rd) !== 0) $display("FAIL basic_stream: %0d bytes differ (got %0d want %0d bytes)", q_diff(got_rd, exp_rd), got_rd.size(), exp_rd.size()); else n_pass++;
        n_checks++; if (done_cnt !== 1)    $display("FAIL basic_done_count: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (css_gap !== T_CSS) $display("FAIL basic_css_cycles: got %0d want %0d", css_gap, T_CSS); else n_pass++;
        n_checks++; if (csh_high !== T_CSH) $display("FAIL basic_csh_cycles: got %0d want %0d", csh_high, T_CSH); else n_pass++;
        n_checks++; if (busy_low !== 0)    $display("FAIL basic_busy_gap: got %0d want 0", busy_low); else n_pass++;
        n_checks++; if (gap_bad !== 0)     $display("FAIL basic_throughput: %0d gaps off, want 0", gap_bad); else n_pass++;
        n_checks++; if (hold_bad !== 0)    $display("FAIL basic_tx_byte_stable: got %0d changes want 0", hold_bad); else n_pass++;
        n_checks++; if (req_cs_high !== 0) $display("FAIL basic_req_cs_high: got %0d want 0", req_cs_high); else n_pass++;
        repeat (3) @(posedge sys_clk);
        #1;
        n_checks++; if (busy !== 1'b0 || cs_n !== 1'b1) $display("FAIL basic_idle: busy %b cs_n %b want 0 1", busy, cs_n); else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_obs();
        eng_lat = int'($urandom_range(1, 4));
        set_table(DUMMY ? 8'h0B : 8'h03, 24'h000425);
        prep_txn(1'b1);
        do_txn(10, exp_rd[0], 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (to_flag !== 1'b0)    $display("FAIL bp_timeout: done not seen"); else n_pass++;
        n_checks++; if (stall_bad !== 0)     $display("FAIL bp_stall_hold: got %0d bad cycles want 0", stall_bad); else n_pass++;
        n_checks++; if (req_in_valid !== 0)  $display("FAIL bp_req_in_valid: got %0d want 0", req_in_valid); else n_pass++;
        n_checks++; if (q_diff(got_mosi, exp_mosi) !== 0) $display("FAIL bp_mosi: %0d bytes differ, want 0", q_diff(got_mosi, exp_mosi)); else n_pass++;
        n_checks++; if (q_diff(got_rd, exp_rd) !== 0) $display("FAIL bp_stream: %0d bytes differ, want 0", q_diff(got_rd, exp_rd)); else n_pass++;
    endtask

    task automatic test_start_ignored();
        int busy_after;
        clear_obs();
        eng_lat = 2;
        set_table(DUMMY ? 8'h0B : 8'h03, 24'h123456);
        prep_txn(1'b0);
        do_txn(0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        busy_after = 0;
        repeat (20) begin
            @(posedge sys_clk); #1;
            if (busy || !cs_n) busy_after++;
        end
        n_checks++; if (to_flag !== 1'b0)   $display("FAIL ign_timeout: done not seen"); else n_pass++;
        n_checks++; if (q_diff(got_mosi, exp_mosi) !== 0) $display("FAIL ign_mosi: %0d bytes differ, want 0", q_diff(got_mosi, exp_mosi)); else n_pass++;
        n_checks++; if (done_cnt !== 1)     $display("FAIL ign_done_count: got %0d want 1", done_cnt); else n_pass++;
        n_checks++; if (busy_after !== 0)   $display("FAIL ign_not_queued: got %0d busy cycles want 0", busy_after); else n_pass++;
    endtask

    task automatic test_back_to_back();
        clear_obs();
        eng_lat = 1;
        set_table(DUMMY ? 8'h0B : 8'h03, 24'h00ABCD);
        prep_txn(1'b0);
        prep_txn(1'b0);
        do_txn(0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        n_checks++; if (to_flag !== 1'b0)   $display("FAIL b2b_first_timeout: done not seen"); else n_pass++;
        do_txn(0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        n_checks++; if (to_flag !== 1'b0)   $display("FAIL b2b_second_timeout: done not seen"); else n_pass++;
        n_checks++; if (busy_low !== 0)     $display("FAIL b2b_busy_continuous: got %0d low cycles want 0", busy_low); else n_pass++;
        n_checks++; if (css_gap !== T_CSS)  $display("FAIL b2b_css_cycles: got %0d want %0d", css_gap, T_CSS); else n_pass++;
        n_checks++; if (done_cnt !== 2)     $display("FAIL b2b_done_count: got %0d want 2", done_cnt); else n_pass++;
        n_checks++; if (q_diff(got_mosi, exp_mosi) !== 0) $display("FAIL b2b_mosi: %0d bytes differ, want 0", q_diff(got_mosi, exp_mosi)); else n_pass++;
        n_checks++; if (q_diff(got_rd, exp_rd) !== 0) $display("FAIL b2b_stream: %0d bytes differ, want 0", q_diff(got_rd, exp_rd)); else n_pass++;
    endtask

    task automatic test_reset_mid();
        bit reached;
        clear_obs();
        eng_lat = 2;
        set_table(DUMMY ? 8'h0B : 8'h03, 24'h000425);
        prep_txn(1'b0);
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        reached = 1'b0;
        for (int t = 0; t < 500 && !reached; t++) begin
            if (got_rd.size() == 2) reached = 1'b1;
            else begin @(posedge sys_clk); #1; end
        end
        n_checks++; if (reached !== 1'b1) $display("FAIL rstmid_reach: got %0d bytes want 2", got_rd.size()); else n_pass++;
        // make sure a byte is pending on the stream when reset hits
        rd_ready = 1'b0;
        for (int t = 0; t < 50 && !rd_valid; t++) begin @(posedge sys_clk); #1; end
        sys_rst_n = 1'b0;
        @(posedge sys_clk); #1;
        n_checks++; if (cs_n !== 1'b1)     $display("FAIL rstmid_cs_n: got %b want 1", cs_n); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rstmid_rd_valid: got %b want 0", rd_valid); else n_pass++;
        n_checks++; if (index !== 8'h00)   $display("FAIL rstmid_index: got %h want 00", index); else n_pass++;
        n_checks++; if (tx_req !== 1'b0 || busy !== 1'b0) $display("FAIL rstmid_req_busy: tx_req %b busy %b want 0 0", tx_req, busy); else n_pass++;
        @(posedge sys_clk); #1;
        sys_rst_n = 1'b1;
        rd_ready  = 1'b1;
        @(posedge sys_clk); #1;
        clear_obs();
        prep_txn(1'b0);
        do_txn(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        n_checks++; if (to_flag !== 1'b0)  $display("FAIL rstmid_after_timeout: done not seen"); else n_pass++;
        n_checks++; if (q_diff(got_mosi, exp_mosi) !== 0) $display("FAIL rstmid_after_mosi: %0d bytes differ, want 0", q_diff(got_mosi, exp_mosi)); else n_pass++;
        n_checks++; if (q_diff(got_rd, exp_rd) !== 0) $display("FAIL rstmid_after_stream: %0d bytes differ, want 0", q_diff(got_rd, exp_rd)); else n_pass++;
    endtask

    task automatic test_random();
        for (int k = 0; k < 4; k++) begin
            clear_obs();
            eng_lat = int'($urandom_range(1, 4));
            set_table(8'($urandom), 24'($urandom));
            prep_txn(1'b0);
            do_txn(0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
            n_checks++; if (to_flag !== 1'b0)   $display("FAIL rnd%0d_timeout: done not seen", k); else n_pass++;
            n_checks++; if (q_diff(got_mosi, exp_mosi) !== 0) $display("FAIL rnd%0d_mosi: %0d bytes differ, want 0", k, q_diff(got_mosi, exp_mosi)); else n_pass++;
            n_checks++; if (q_diff(got_rd, exp_rd) !== 0) $display("FAIL rnd%0d_stream: %0d bytes differ, want 0", k, q_diff(got_rd, exp_rd)); else n_pass++;
            n_checks++; if (req_in_valid !== 0 || hold_bad !== 0) $display("FAIL rnd%0d_protocol: req_in_valid %0d hold_bad %0d want 0 0", k, req_in_valid, hold_bad); else n_pass++;
            n_checks++; if (csh_high !== T_CSH) $display("FAIL rnd%0d_csh_cycles: got %0d want %0d", k, csh_high, T_CSH); else n_pass++;
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        start     = 1'b0;
        rd_ready  = 1'b1;
        set_table(8'h03, 24'h000425);
        test_reset();
        test_basic();
        test_backpressure();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
